// File: rtl/bram_access_controller_pkg.sv
// Shared encodings and lane helpers for initiators that drive a byte-enabled 32-bit BRAM port.
// Used by the access controller and by the load-alignment block.
package bram_access_controller_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } size_e;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic       write;
        logic [1:0] size;
        logic       isSigned;
        logic [1:0] offset;
        logic       error;
    } pending_t;

    function automatic logic isBadRequest(input logic [1:0] size, input logic [1:0] offset);
        return (size == SIZE_ILLEGAL) ||
               ((size == SIZE_HALF) && offset[0]) ||
               ((size == SIZE_WORD) && (offset != 2'd0));
    endfunction

    function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'b0001 << offset;
            SIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // Shift the addressed lane down to bit 0, then mask and extend to the access size.
    function automatic logic [31:0] loadExtract(input logic [31:0] rdata, input logic [1:0] size,
                                                input logic isSigned, input logic [1:0] offset);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = rdata >> {offset, 3'b000};
        case (size)
            SIZE_BYTE: result = {{24{isSigned & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: result = {{16{isSigned & shifted[15]}}, shifted[15:0]};
            default:   result = shifted;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/bram_access_controller_load_align.sv
// Combinational re-alignment of a BRAM read word into a right-aligned, extended load result.
// Kept separate so other BRAM initiators can share it.
module bram_load_align
    import bram_access_controller_pkg::*;
(
    input  logic [31:0] i_readData,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_rdata
);

    always_comb begin
        o_rdata = loadExtract(i_readData, i_size, i_signed, i_offset);
    end

endmodule

// File: rtl/bram_access_controller.sv
// Core-side load/store front end for one port of a byte-enabled BRAM: optional clear after reset,
// then a two-stage (issue, response) pipeline returning in-order responses.
module bram_access_controller
    import bram_access_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic                  init_done,
    output logic                  readEnable,
    output logic                  writeEnable,
    output logic [3:0]            writeByteEnable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] writeData,
    input  logic [DATA_WIDTH-1:0] readData
);

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_initCount;
    logic                  r_pValid;
    pending_t              r_p;
    logic                  r_rValid;
    logic [31:0]           r_rData;
    logic                  r_rError;

    logic                  w_active;
    logic                  w_run;
    logic [1:0]            w_offset;
    logic                  w_error;
    logic                  w_accept;
    logic                  w_pToR;
    logic [31:0]           w_alignData;

    assign w_active = !reset;
    assign w_run    = w_active && (r_state == ST_RUN);
    assign w_offset = req_addr[1:0];
    assign w_error  = isBadRequest(req_size, w_offset);

    assign req_ready = w_run && (!r_pValid || !r_rValid || resp_ready);
    assign w_accept  = req_valid && req_ready;
    assign w_pToR    = r_pValid && (!r_rValid || resp_ready);

    assign resp_valid = r_rValid;
    assign resp_rdata = r_rData;
    assign resp_error = r_rError;
    assign init_done  = w_run;

    bram_load_align u_loadAlign (
        .i_readData (readData),
        .i_offset   (r_p.offset),
        .i_size     (r_p.size),
        .i_signed   (r_p.isSigned),
        .o_rdata    (w_alignData)
    );

    // BRAM port is driven only while clearing or in the cycle a legal request is accepted.
    always_comb begin
        readEnable      = 1'b0;
        writeEnable     = 1'b0;
        writeByteEnable = 4'b0000;
        address         = '0;
        writeData       = '0;
        if (w_active && (r_state == ST_INIT)) begin
            writeEnable     = 1'b1;
            writeByteEnable = 4'b1111;
            address         = r_initCount;
        end else if (w_accept && !w_error) begin
            address = req_addr[ADDR_WIDTH+1:2];
            if (req_write) begin
                writeEnable     = 1'b1;
                writeByteEnable = byteEnable(req_size, w_offset);
                case (req_size)
                    SIZE_BYTE: writeData = {4{req_wdata[7:0]}};
                    SIZE_HALF: writeData = {2{req_wdata[15:0]}};
                    default:   writeData = req_wdata;
                endcase
            end else begin
                readEnable = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= INIT_CLEAR ? ST_INIT : ST_RUN;
            r_initCount <= '0;
        end else if (r_state == ST_INIT) begin
            r_initCount <= r_initCount + 1'b1;
            if (&r_initCount) begin
                r_state <= ST_RUN;
            end
        end
    end

    // readData belongs to P only in the cycle after issue; a stall blocks new reads, so it still holds.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pValid <= 1'b0;
            r_p      <= '0;
            r_rValid <= 1'b0;
            r_rData  <= '0;
            r_rError <= 1'b0;
        end else begin
            if (w_pToR) begin
                r_rValid <= 1'b1;
                r_rError <= r_p.error;
                r_rData  <= (r_p.write || r_p.error) ? 32'd0 : w_alignData;
            end else if (resp_ready) begin
                r_rValid <= 1'b0;
            end

            if (w_accept) begin
                r_pValid <= 1'b1;
                r_p      <= '{write: req_write, size: req_size, isSigned: req_signed,
                              offset: w_offset, error: w_error};
            end else if (w_pToR) begin
                r_pValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bram_access_controller.sv
// Directed bench for bram_access_controller with a behavioural byte-enabled BRAM behind it.
// Covers the post-reset clear, store/load lane handling, error requests, stalls and mid-run reset.
module tb_bram_access_controller;
    import bram_access_controller_pkg::*;

    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic          init_done;
    logic          readEnable;
    logic          writeEnable;
    logic [3:0]    writeByteEnable;
    logic [AW-1:0] address;
    logic [31:0]   writeData;
    logic [31:0]   readData = 32'd0;

    logic [31:0]   mem [0:(1<<AW)-1];

    int            checks = 0;
    int            errors = 0;
    int            initBad = 0;
    int            staleCount = 0;
    logic          logEnable = 1'b0;
    logic          staleWatch = 1'b0;
    logic [31:0]   respLog [$];

    bram_access_controller #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (32),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_error      (resp_error),
        .init_done       (init_done),
        .readEnable      (readEnable),
        .writeEnable     (writeEnable),
        .writeByteEnable (writeByteEnable),
        .address         (address),
        .writeData       (writeData),
        .readData        (readData)
    );

    always #5 clock = ~clock;

    // Behavioural BRAM port: byte-lane writes, registered read that holds when not enabled.
    always @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (writeEnable && writeByteEnable[b]) begin
                mem[address][8*b +: 8] <= writeData[8*b +: 8];
            end
        end
        if (readEnable) begin
            readData <= mem[address];
        end
    end

    // Records completed response handshakes and flags any response seen while it should be idle.
    always @(posedge clock) begin
        if (logEnable && resp_valid && resp_ready) begin
            respLog.push_back(resp_rdata);
        end
        if (staleWatch && resp_valid) begin
            staleCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic write, input logic [1:0] size, input logic sgn,
                                 input logic [AW+1:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_write  = write;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic idleRequest();
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
    endtask

    // One request with free-flowing responses: checks port controls at issue and the response two edges on.
    task automatic runTransaction(input string tag, input logic write, input logic [1:0] size,
                                  input logic sgn, input logic [AW+1:0] addr, input logic [31:0] wdata,
                                  input logic expWe, input logic expRe, input logic [3:0] expBe,
                                  input logic [AW-1:0] expAddr, input logic [31:0] expWd,
                                  input logic [31:0] expRdata, input logic expErr);
        @(negedge clock);
        applyStimulus(write, size, sgn, addr, wdata);
        #1;
        checkOutput({tag, ".reqReady"}, req_ready, 1);
        checkOutput({tag, ".we"}, writeEnable, expWe);
        checkOutput({tag, ".re"}, readEnable, expRe);
        checkOutput({tag, ".be"}, writeByteEnable, expBe);
        checkOutput({tag, ".addr"}, address, expAddr);
        if (expWe) checkOutput({tag, ".wdata"}, writeData, expWd);
        @(posedge clock);
        #1;
        idleRequest();
        checkOutput({tag, ".notYetValid"}, resp_valid, 0);
        @(posedge clock);
        #1;
        checkOutput({tag, ".respValid"}, resp_valid, 1);
        checkOutput({tag, ".respData"}, resp_rdata, expRdata);
        checkOutput({tag, ".respError"}, resp_error, expErr);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 32'h5A5A5A5A ^ (i * 32'h01010101);
        end
        reset      = 1'b1;
        resp_ready = 1'b1;
        idleRequest();

        @(posedge clock);
        @(posedge clock);
        #1;
        checkOutput("reset.reqReady", req_ready, 0);
        checkOutput("reset.respValid", resp_valid, 0);
        checkOutput("reset.respData", resp_rdata, 0);
        checkOutput("reset.respError", resp_error, 0);
        checkOutput("reset.initDone", init_done, 0);
        checkOutput("reset.we", writeEnable, 0);
        checkOutput("reset.be", writeByteEnable, 0);

        @(negedge clock);
        reset = 1'b0;
        $display("[TB] clearing phase");
        for (int i = 0; i < (1 << AW); i++) begin
            #1;
            if (!(writeEnable === 1'b1 && readEnable === 1'b0 && writeByteEnable === 4'hF &&
                  writeData === 32'd0 && address === i[AW-1:0] && req_ready === 1'b0 &&
                  init_done === 1'b0)) begin
                initBad++;
            end
            @(negedge clock);
        end
        #1;
        checkOutput("init.badCycles", initBad, 0);
        checkOutput("init.done", init_done, 1);
        checkOutput("init.weOff", writeEnable, 0);
        checkOutput("init.reqReady", req_ready, 1);
        checkOutput("init.mem0", mem[0], 0);
        checkOutput("init.mem255", mem[255], 0);

        $display("[TB] directed load/store sequence");
        runTransaction("ldTop",    0, SIZE_WORD, 0, 'h3FC, 0,            0, 1, 4'h0, 8'hFF, 0,            32'h00000000, 0);
        runTransaction("stWord",   1, SIZE_WORD, 0, 'h010, 32'hDEADBEEF, 1, 0, 4'hF, 8'h04, 32'hDEADBEEF, 32'h00000000, 0);
        runTransaction("ldWord",   0, SIZE_WORD, 0, 'h010, 0,            0, 1, 4'h0, 8'h04, 0,            32'hDEADBEEF, 0);
        runTransaction("stByte",   1, SIZE_BYTE, 0, 'h013, 32'h123456AA, 1, 0, 4'h8, 8'h04, 32'hAAAAAAAA, 32'h00000000, 0);
        runTransaction("ldByteS",  0, SIZE_BYTE, 1, 'h013, 0,            0, 1, 4'h0, 8'h04, 0,            32'hFFFFFFAA, 0);
        runTransaction("ldByteU",  0, SIZE_BYTE, 0, 'h013, 0,            0, 1, 4'h0, 8'h04, 0,            32'h000000AA, 0);
        runTransaction("ldMerged", 0, SIZE_WORD, 0, 'h010, 0,            0, 1, 4'h0, 8'h04, 0,            32'hAAADBEEF, 0);
        runTransaction("stHalf",   1, SIZE_HALF, 0, 'h022, 32'h00008001, 1, 0, 4'hC, 8'h08, 32'h80018001, 32'h00000000, 0);
        runTransaction("ldHalfS",  0, SIZE_HALF, 1, 'h022, 0,            0, 1, 4'h0, 8'h08, 0,            32'hFFFF8001, 0);
        runTransaction("stHalfOdd",1, SIZE_HALF, 0, 'h021, 32'h00001234, 0, 0, 4'h0, 8'h00, 0,            32'h00000000, 1);
        runTransaction("ldWordMis",0, SIZE_WORD, 0, 'h012, 0,            0, 0, 4'h0, 8'h00, 0,            32'h00000000, 1);
        runTransaction("ldIllegal",0, SIZE_ILLEGAL, 1, 'h010, 0,         0, 0, 4'h0, 8'h00, 0,            32'h00000000, 1);
        runTransaction("ldAfterErr",0, SIZE_HALF, 0, 'h022, 0,           0, 1, 4'h0, 8'h08, 0,            32'h00008001, 0);
        checkOutput("mem8", mem[8], 32'h80010000);

        $display("[TB] back-to-back loads with response stall");
        @(posedge clock);
        #1;
        respLog.delete();
        logEnable = 1'b1;
        @(negedge clock);
        applyStimulus(0, SIZE_WORD, 0, 'h010, 0);
        @(posedge clock);
        #1;
        applyStimulus(0, SIZE_BYTE, 0, 'h013, 0);
        @(posedge clock);
        #1;
        checkOutput("b2b.firstValid", resp_valid, 1);
        checkOutput("b2b.firstData", resp_rdata, 32'hAAADBEEF);
        resp_ready = 1'b0;
        applyStimulus(0, SIZE_HALF, 0, 'h022, 0);
        #1;
        checkOutput("b2b.readyDrop", req_ready, 0);
        checkOutput("b2b.noReadWhileStalled", readEnable, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            checkOutput("b2b.stallValid", resp_valid, 1);
            checkOutput("b2b.stallData", resp_rdata, 32'hAAADBEEF);
            checkOutput("b2b.stallReady", req_ready, 0);
        end
        resp_ready = 1'b1;
        #1;
        checkOutput("b2b.readyBack", req_ready, 1);
        @(posedge clock);
        #1;
        idleRequest();
        checkOutput("b2b.secondData", resp_rdata, 32'h000000AA);
        @(posedge clock);
        #1;
        checkOutput("b2b.thirdData", resp_rdata, 32'h00008001);
        @(posedge clock);
        #1;
        checkOutput("b2b.drained", resp_valid, 0);
        logEnable = 1'b0;
        checkOutput("b2b.logCount", respLog.size(), 3);
        if (respLog.size() == 3) begin
            checkOutput("b2b.log0", respLog[0], 32'hAAADBEEF);
            checkOutput("b2b.log1", respLog[1], 32'h000000AA);
            checkOutput("b2b.log2", respLog[2], 32'h00008001);
        end

        $display("[TB] reset with a load in flight");
        @(negedge clock);
        applyStimulus(0, SIZE_WORD, 0, 'h010, 0);
        @(posedge clock);
        #1;
        idleRequest();
        reset = 1'b1;
        #1;
        checkOutput("midReset.respValid", resp_valid, 0);
        checkOutput("midReset.reqReady", req_ready, 0);
        checkOutput("midReset.initDone", init_done, 0);
        checkOutput("midReset.we", writeEnable, 0);
        @(negedge clock);
        reset = 1'b0;
        staleWatch = 1'b1;
        #1;
        checkOutput("reInit.we", writeEnable, 1);
        checkOutput("reInit.addr", address, 0);
        checkOutput("reInit.initDone", init_done, 0);
        for (int cyc = 0; cyc < 300 && init_done !== 1'b1; cyc++) begin
            @(negedge clock);
        end
        checkOutput("reInit.doneReached", init_done, 1);
        @(posedge clock);
        @(posedge clock);
        #1;
        staleWatch = 1'b0;
        checkOutput("reInit.staleCount", staleCount, 0);
        checkOutput("reInit.respValid", resp_valid, 0);
        runTransaction("ldCleared", 0, SIZE_WORD, 0, 'h010, 0, 0, 1, 4'h0, 8'h04, 0, 32'h00000000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_access_controller.md
Name: bram_access_controller

Overview:
- Initiator that drives one port of dual_port_BRAM_byte_en on behalf of a core-side load/store requester.
- Converts byte-addressed byte/half/word requests into word address, writeByteEnable and lane-aligned writeData.
- Re-aligns and sign- or zero-extends read data, then returns in-order responses over a valid/ready handshake.
- Optionally zero-clears the whole BRAM after reset, before accepting any request.

Parameters:
- ADDR_WIDTH, 8, BRAM word-address width; request byte address is ADDR_WIDTH+2 bits.
- DATA_WIDTH, 32, word width; fixed at 32 (4 byte lanes).
- INIT_CLEAR, 1, 1 = write zero to every word after reset; 0 = go straight to RUN.

Ports:
- clock  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on clock edge when req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed on edge when resp_valid & resp_ready.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  misaligned or illegal-size request.
- init_done  out  1  high once RUN is entered.
- readEnable  out  1  to BRAM port.
- writeEnable  out  1  to BRAM port.
- writeByteEnable  out  4  to BRAM port.
- address  out  ADDR_WIDTH  to BRAM port.
- writeData  out  32  to BRAM port.
- readData  in  32  from BRAM; valid after the edge that sampled readEnable.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0, init_done=0, all BRAM controls 0. State = INIT if INIT_CLEAR, else RUN.
- Reset mid-operation drops pending and response stages. Lost responses are not replayed.
- INIT state:
  - Counter walks 0 to 2^ADDR_WIDTH-1, one word per cycle: writeEnable=1, writeByteEnable=1111, writeData=0, readEnable=0.
  - After the last word (2^ADDR_WIDTH cycles), enter RUN and set init_done=1.
  - req_ready=0 throughout INIT.
- RUN, two registered stages: P (issued, awaiting readData) and R (response register).
  - req_ready = RUN & (!P.valid | !R.valid | resp_ready).
  - BRAM controls are combinational from the request when accepted (req_valid & req_ready), else all 0.
- Legal accepted request:
  - address = req_addr[ADDR_WIDTH+1:2]; offset o = req_addr[1:0].
  - Store: writeEnable=1, readEnable=0.
    - Byte: BE = 1<<o, writeData = 4 copies of req_wdata[7:0].
    - Half: BE = 0011 (o=0) or 1100 (o=2), writeData = 2 copies of req_wdata[15:0].
    - Word: BE = 1111, writeData = req_wdata.
  - Load: readEnable=1, writeEnable=0, BE=0000.
- Error request: no BRAM access (all controls 0). Error cases:
  - size 3;
  - half with o odd;
  - word with o != 0.
- Every accepted request loads P with {write, size, signed, o, error}.
- P to R on edge when P.valid & (!R.valid | resp_ready). For loads, resp_rdata is formed from readData at that edge:
  - shift right 8*o;
  - mask to 8 or 16 bits by size;
  - sign-extend if req_signed, else zero-extend.
- Stores and errors give resp_rdata=0.
- Latency: request accepted at edge N gives resp_valid high after edge N+1. Throughput is one request per cycle with resp_ready held high.
- Stall: R holds while resp_valid & !resp_ready. P holds; the BRAM is not re-read. readData is only sampled on the P-to-R transfer in the cycle after issue, because P cannot be pending while R is full and stalled without req_ready=0.
- Ordering: responses return strictly in request order; errors are in-order too.
- Simultaneous P-to-R transfer and new accept in the same edge is legal (pipeline advances).

Decomposition:
- Shared package holds:
  - size encodings SIZE_BYTE/HALF/WORD;
  - state encodings INIT/RUN;
  - a function for byte-enable generation;
  - a function for load extract/extend.
- One natural sub-module: bram_load_align (combinational readData + offset/size/signed -> resp_rdata), reusable by other BRAM initiators.

Test Plan:
- Reset with INIT_CLEAR=1, ADDR_WIDTH=8 -> req_ready=0 for 256 cycles with writeEnable=1, BE=1111, data 0 on addresses 0..255; then init_done=1; a load of word 0x3FC returns 0.
- Word store 0xDEADBEEF to addr 0x10, then word load 0x10 -> BRAM address 4, BE=1111; response 0xDEADBEEF two edges after accept, resp_error=0.
- Byte store 0xAA to addr 0x13 -> BE=1000, writeData=0xAAAAAAAA; then:
  - signed byte load 0x13 -> 0xFFFFFFAA;
  - unsigned byte load 0x13 -> 0x000000AA;
  - word load 0x10 -> 0xAAADBEEF.
- Half store 0x8001 to addr 0x22 -> BE=1100; signed half load 0x22 -> 0xFFFF8001; half store to 0x21 -> no BRAM write, resp_error=1, resp_rdata=0.
- Back-to-back loads of 0x10, 0x13, 0x22 with resp_ready low for 3 cycles after the first response -> req_ready drops; responses emerge in order 0xAAADBEEF, 0x000000AA, 0x00008001 with no loss or duplication.
- Assert reset while a load is in P -> resp_valid=0 immediately; controller restarts INIT; no stale response after init_done.
